// File: rtl/ram2_ctrl.sv
// Bus master for a single-port RAM with a shared bidirectional data bus.
// Sequences single read/write requests and a full-depth CLEAR sweep.
module ram2_ctrl #(
   parameter int                    ADDR_WIDTH = 5,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   input  logic                  clr_start,
   output logic                  clr_done,
   output logic                  busy,
   output logic                  ram_ena,
   output logic                  ram_wena,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_CLEAR = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  last;
   logic                  ena_d;
   logic                  wena_d;

   assign last = (cnt == {ADDR_WIDTH{1'b1}});

   // Bus is driven only in write-type cycles; the RAM drives only when ena=1, wena=0.
   assign ram_data = (ram_ena && ram_wena) ? wdata_q : {DATA_WIDTH{1'bz}};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (clr_start)      next_state = S_CLEAR;
            else if (req_valid) next_state = req_we ? S_WRITE : S_READ;
         end
         S_WRITE: next_state = S_DONE;
         S_READ:  next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         S_CLEAR: next_state = last ? S_IDLE : S_CLEAR;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE) && !rst && !clr_start;
      rsp_valid = (state == S_DONE);
      busy      = (state != S_IDLE);
      ena_d     = (next_state == S_WRITE) || (next_state == S_READ) || (next_state == S_CLEAR);
      wena_d    = (next_state == S_WRITE) || (next_state == S_CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_ena   <= 1'b0;
         ram_wena  <= 1'b0;
         ram_addr  <= '0;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         clr_done  <= 1'b0;
         cnt       <= '0;
      end else begin
         ram_ena  <= ena_d;
         ram_wena <= wena_d;
         clr_done <= (state == S_CLEAR) && last;
         case (state)
            S_IDLE: begin
               if (clr_start) begin
                  cnt      <= '0;
                  ram_addr <= '0;
                  wdata_q  <= CLR_VALUE;
               end else if (req_valid) begin
                  ram_addr <= req_addr;
                  wdata_q  <= req_wdata;
               end
            end
            S_READ: rsp_rdata <= ram_data;
            S_CLEAR: begin
               // Counter stops at the top address so the sweep never wraps.
               if (!last) begin
                  cnt      <= cnt + ADDR_WIDTH'(1);
                  ram_addr <= cnt + ADDR_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
